// File: rtl/pwm_capture_if.sv
// Bus between a PWM capture block and whatever consumes its measurements.
//
// Handshake: meas_valid is a one-cycle pulse with no ready. period_meas and
// high_meas are valid in the cycle meas_valid is high and stay unchanged until
// the next pulse. The consumer has no backpressure and must take the result in
// that cycle.
interface pwm_capture_if #(
  parameter int WIDTH = 16
);
  logic             cap_en;
  logic             ovf_clr;
  logic             pwm_in;
  logic [WIDTH-1:0] period_meas;
  logic [WIDTH-1:0] high_meas;
  logic             meas_valid;
  logic             overflow;
  // FSM state for debug: 0 IDLE, 1 WAIT_RISE, 2 HIGH, 3 LOW
  logic [1:0]       state_dbg;

  // Controller / source side
  modport master (
    output cap_en, ovf_clr, pwm_in,
    input  period_meas, high_meas, meas_valid, overflow, state_dbg
  );

  // Capture block side
  modport slave (
    input  cap_en, ovf_clr, pwm_in,
    output period_meas, high_meas, meas_valid, overflow, state_dbg
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of each complete PWM cycle in clk
// cycles. Counters saturate instead of wrapping, and saturation sets a sticky
// overflow flag.
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_d;
  logic                   lvl_s;
  logic                   rise;
  logic                   fall;

  state_t           state_q;
  state_t           state_nxt;
  logic [WIDTH-1:0] per_q;
  logic [WIDTH-1:0] per_nxt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] hi_nxt;
  logic             publish;
  logic             saturate;

  logic [WIDTH-1:0] period_meas_q;
  logic [WIDTH-1:0] high_meas_q;
  logic             meas_valid_q;
  logic             overflow_q;

  // Synchroniser chain plus one delayed copy used for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      lvl_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      lvl_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl_s = sync_q[SYNC_STAGES-1];
  assign rise  = lvl_s & ~lvl_d;
  assign fall  = ~lvl_s & lvl_d;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state, counter updates, publish and saturation decisions
  always_comb begin
    state_nxt = state_q;
    per_nxt   = per_q;
    hi_nxt    = hi_q;
    publish   = 1'b0;
    saturate  = 1'b0;
    if (!bus.cap_en) begin
      state_nxt = IDLE;
      per_nxt   = '0;
      hi_nxt    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_nxt = WAIT_RISE;
          per_nxt   = '0;
          hi_nxt    = '0;
        end
        WAIT_RISE: begin
          // The cycle in progress at enable is partial, so it is discarded
          if (rise) begin
            state_nxt = HIGH;
            per_nxt   = CNT_ONE;
            hi_nxt    = CNT_ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            // A fall with the period already at max leaves no legal period
            if (per_q == CNT_MAX) begin
              saturate = 1'b1;
            end else begin
              state_nxt = LOW;
              per_nxt   = per_q + CNT_ONE;
            end
          end else if (per_q == CNT_MAX || hi_q == CNT_MAX) begin
            saturate = 1'b1;
          end else begin
            per_nxt = per_q + CNT_ONE;
            hi_nxt  = hi_q + CNT_ONE;
          end
        end
        LOW: begin
          // An edge in the saturating cycle wins, so a max period publishes
          if (rise) begin
            publish   = 1'b1;
            state_nxt = HIGH;
            per_nxt   = CNT_ONE;
            hi_nxt    = CNT_ONE;
          end else if (per_q == CNT_MAX) begin
            saturate = 1'b1;
          end else begin
            per_nxt = per_q + CNT_ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (saturate) begin
        state_nxt = WAIT_RISE;
      end
    end
  end

  // Counters, published results and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      per_q         <= '0;
      hi_q          <= '0;
      period_meas_q <= '0;
      high_meas_q   <= '0;
      meas_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      per_q        <= per_nxt;
      hi_q         <= hi_nxt;
      meas_valid_q <= publish;
      if (publish) begin
        period_meas_q <= per_q;
        high_meas_q   <= hi_q;
      end
      if (saturate) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.period_meas = period_meas_q;
  assign bus.high_meas   = high_meas_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture. The reference model works on timestamps of source
// edges: each new rise closes a period (rise-to-rise) whose high time is
// fall-minus-rise, and a gap longer than the counter range sets overflow.
module tb_pwm_capture;

  localparam int W   = 8;
  localparam int SS  = 2;
  localparam int MAX = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_capture_if #(.WIDTH(W)) bus ();

  pwm_capture #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int       t         = 0;
  logic     prev_lvl  = 1'b0;
  bit       cap_active = 1'b0;
  bit       has_rise  = 1'b0;
  int       last_rise = 0;
  int       last_fall = 0;
  bit       ovf_exp   = 1'b0;
  logic [W-1:0] last_per = '0;
  logic [W-1:0] last_hi  = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0d)", name, act, exp, t);
    end
  endtask

  // One source cycle: a rise closes the running period, a gap longer than
  // the counter range means the capture gave up on that period.
  task automatic model_step(input logic lvl);
    t++;
    if (has_rise && (t - last_rise) == MAX + 1) begin
      ovf_exp  = 1'b1;
      has_rise = 1'b0;
    end
    if (lvl && !prev_lvl) begin
      if (has_rise) begin
        last_per = W'(t - last_rise);
        last_hi  = W'(last_fall - last_rise);
        exp_q.push_back({last_per, last_hi});
      end
      has_rise  = cap_active;
      last_rise = t;
    end
    if (!lvl && prev_lvl) last_fall = t;
    prev_lvl = lvl;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic lvl);
    @(posedge clk);
    #1;
    bus.pwm_in = lvl;
    model_step(lvl);
  endtask

  task automatic seg(input logic lvl, input int n);
    repeat (n) drive(lvl);
  endtask

  task automatic pwm_cycles(input int hi, input int lo, input int n);
    repeat (n) begin
      seg(1'b1, hi);
      seg(1'b0, lo);
    end
  endtask

  task automatic set_cap(input logic v);
    bus.cap_en = v;
    cap_active = v;
    has_rise   = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.ovf_clr = 1'b1;
    drive(prev_lvl);
    bus.ovf_clr = 1'b0;
    ovf_exp = 1'b0;
  endtask

  task automatic check_ovf(input string name);
    @(negedge clk);
    check(name, int'(bus.overflow), int'(ovf_exp));
  endtask

  // ---------------- monitor ----------------
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.meas_valid) begin
        check("valid_not_back_to_back", int'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=%0d/%0d expected=none",
                   bus.period_meas, bus.high_meas);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          check("period_meas", int'(bus.period_meas), int'(e[2*W-1:W]));
          check("high_meas", int'(bus.high_meas), int'(e[W-1:0]));
        end
      end
      prev_valid = bus.meas_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    bus.cap_en  = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.pwm_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_period", int'(bus.period_meas), 0);
    check("reset_high", int'(bus.high_meas), 0);
    check("reset_valid", int'(bus.meas_valid), 0);
    check("reset_overflow", int'(bus.overflow), 0);
    check("reset_state_idle", int'(bus.state_dbg), 0);

    // Basic 10/3 source, then generator-like 20/5, then fastest 2/1
    set_cap(1'b1);
    seg(1'b0, 5);
    pwm_cycles(3, 7, 8);
    pwm_cycles(5, 15, 5);
    pwm_cycles(1, 1, 20);
    seg(1'b1, 3);
    seg(1'b0, 6);
    check_ovf("overflow_after_normal");

    // Random duty and period
    for (int i = 0; i < 40; i++) begin
      pwm_cycles($urandom_range(1, 20), $urandom_range(1, 20), 1);
    end

    // Capture disabled mid-HIGH: outputs hold, FSM idles, partial cycle dropped
    pwm_cycles(6, 6, 2);
    seg(1'b1, 6);
    set_cap(1'b0);
    seg(1'b1, 3);
    @(negedge clk);
    check("held_period", int'(bus.period_meas), int'(last_per));
    check("held_high", int'(bus.high_meas), int'(last_hi));
    check("disabled_state_idle", int'(bus.state_dbg), 0);
    set_cap(1'b1);
    seg(1'b1, 6);
    seg(1'b0, 6);
    pwm_cycles(5, 7, 3);

    // 0% duty saturates, clear, then 8/4 source
    seg(1'b0, 300);
    check_ovf("overflow_low_hold");
    pulse_clr();
    check_ovf("overflow_cleared");
    seg(1'b0, 4);
    pwm_cycles(4, 4, 5);

    // 100% duty saturates
    seg(1'b1, 300);
    seg(1'b0, 10);
    check_ovf("overflow_high_hold");
    pulse_clr();
    check_ovf("overflow_cleared_2");

    // Period exactly max publishes; one more cycle overflows instead
    seg(1'b0, 5);
    pwm_cycles(100, 155, 2);
    seg(1'b1, 100);
    seg(1'b0, 156);
    seg(1'b1, 5);
    seg(1'b0, 5);
    check_ovf("overflow_period_max_plus_one");
    pulse_clr();
    pwm_cycles(3, 3, 3);

    // Reset pulse mid-LOW
    seg(1'b1, 4);
    seg(1'b0, 6);
    rst = 1'b1;
    drive(1'b0);
    rst = 1'b0;
    has_rise = 1'b0;
    ovf_exp  = 1'b0;
    @(negedge clk);
    check("rst_mid_period", int'(bus.period_meas), 0);
    check("rst_mid_high", int'(bus.high_meas), 0);
    check("rst_mid_valid", int'(bus.meas_valid), 0);
    check("rst_mid_overflow", int'(bus.overflow), 0);
    check("rst_mid_state_idle", int'(bus.state_dbg), 0);
    seg(1'b0, 4);
    pwm_cycles(3, 7, 4);

    // Drain and report
    seg(1'b0, 10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
